abs_share_arbiter: RTL and testbench

- Shares one saturating 8-bit signed-to-magnitude unit between N requesters.
- Arbitration is round-robin over valid/ready handshakes.
- Results are registered and tagged with the requester ID; output has backpressure.
- Also tracks the peak magnitude and counts saturation events (-128 inputs) for status readout.
- Sits between the sample sources and the downstream magnitude consumer.

---
 rtl/abs_share_arbiter_if.sv | 25 ++
 rtl/abs_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_abs_share_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/abs_share_arbiter_if.sv
// Handshake bundle between the sample sources, the shared magnitude unit and
// the downstream magnitude consumer.
interface abs_share_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [6:0]     out_data;
  logic [IDW-1:0] out_id;
  logic           out_sat;
  logic           out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_sat
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_sat
  );
endinterface

// File: rtl/abs_share_arbiter.sv
// Round-robin shared saturating signed-to-magnitude unit with a single
// registered, ID-tagged output stage plus peak and saturation-event status.
module abs_share_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  abs_share_arbiter_if.slave    bus,
  input  logic                  peak_clr_i,
  output logic [6:0]            peak_mag_o,
  output logic [IDW-1:0]        peak_id_o,
  output logic [7:0]            sat_cnt_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [6:0]     out_data_q, out_data_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic           out_sat_q, out_sat_d;
  logic [6:0]     peak_mag_q, peak_mag_d;
  logic [IDW-1:0] peak_id_q, peak_id_d;
  logic [7:0]     sat_cnt_q, sat_cnt_d;

  logic           adv;
  logic [2*N-1:0] rot2;
  logic [N-1:0]   rot;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int             grant_pos;
  logic           xfer;
  logic [7:0]     sample;
  logic [6:0]     mag;
  logic           sat;
  logic [6:0]     base_mag;
  logic [IDW-1:0] base_id;
  logic [7:0]     base_cnt;

  // Rotating the valid vector by ptr lets a fixed priority scan start at ptr.
  always_comb begin
    adv         = !out_valid_q || bus.out_ready;
    rot2        = {bus.req_valid, bus.req_valid} >> ptr_q;
    rot         = rot2[N-1:0];
    grant_found = 1'b0;
    grant_pos   = 0;
    grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_found = 1'b1;
        grant_pos   = int'(ptr_q) + k;
      end
    end
    if (grant_pos >= N) grant_pos = grant_pos - N;
    grant_idx = IDW'(grant_pos);
    xfer      = adv && grant_found && !rst_i;

    sample = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) sample = bus.req_data[i*8 +: 8];
    end

    sat = 1'b0;
    if (!sample[7]) begin
      mag = sample[6:0];
    end else if (sample == 8'h80) begin
      mag = 7'h7F;
      sat = 1'b1;
    end else begin
      mag = ~sample[6:0] + 7'd1;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready = {{(N-1){1'b0}}, 1'b1} << grant_idx;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_sat_d   = out_sat_q;

    if (xfer) begin
      ptr_d       = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = mag;
      out_id_d    = grant_idx;
      out_sat_d   = sat;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end

    // Clear takes effect before a same-cycle sample is folded in.
    base_mag = peak_clr_i ? 7'd0 : peak_mag_q;
    base_id  = peak_clr_i ? '0 : peak_id_q;
    base_cnt = peak_clr_i ? 8'd0 : sat_cnt_q;

    peak_mag_d = base_mag;
    peak_id_d  = base_id;
    sat_cnt_d  = base_cnt;
    if (xfer) begin
      if (mag > base_mag) begin
        peak_mag_d = mag;
        peak_id_d  = grant_idx;
      end
      if (sat && base_cnt != 8'hFF) sat_cnt_d = base_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
      peak_mag_q  <= '0;
      peak_id_q   <= '0;
      sat_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_sat_q   <= out_sat_d;
      peak_mag_q  <= peak_mag_d;
      peak_id_q   <= peak_id_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_sat   = out_sat_q;
  assign peak_mag_o    = peak_mag_q;
  assign peak_id_o     = peak_id_q;
  assign sat_cnt_o     = sat_cnt_q;

endmodule

// File: tb/tb_abs_share_arbiter.sv
// Directed bench for abs_share_arbiter: a cycle model predicts grants and
// status, results are queued on accept and compared when presented.
module tb_abs_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           peak_clr;
  logic [6:0]     peak_mag;
  logic [IDW-1:0] peak_id;
  logic [7:0]     sat_cnt;

  abs_share_arbiter_if #(.N(N), .IDW(IDW)) bus();

  abs_share_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .peak_clr_i (peak_clr),
    .peak_mag_o (peak_mag),
    .peak_id_o  (peak_id),
    .sat_cnt_o  (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]     data;
    logic [IDW-1:0] id;
    logic           sat;
  } res_t;

  res_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           mptr, mpeak, mpid, mcnt;
  bit           mov;
  logic [N-1:0] seen_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_mag(input logic [7:0] x, output int m, output bit s);
    int v;
    v = int'($signed(x));
    s = (x == 8'h80);
    m = s ? 127 : ((v < 0) ? -v : v);
  endfunction

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[i*8 +: 8] = v;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit           adv;
    int           g, idx, m;
    bit           s;
    logic [N-1:0] exp_ready;
    res_t         r;
    @(negedge clk);
    adv = !mov || bus.out_ready;
    g   = -1;
    if (adv && !rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    seen_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("out_valid", 32'(bus.out_valid), 32'(mov));
    if (mov && sb.size() > 0) begin
      check("out_data", 32'(bus.out_data), 32'(sb[0].data));
      check("out_id", 32'(bus.out_id), 32'(sb[0].id));
      check("out_sat", 32'(bus.out_sat), 32'(sb[0].sat));
    end
    check("peak_mag", 32'(peak_mag), 32'(mpeak));
    check("peak_id", 32'(peak_id), 32'(mpid));
    check("sat_cnt", 32'(sat_cnt), 32'(mcnt));
    @(posedge clk);
    if (rst) begin
      mptr = 0; mov = 0; mpeak = 0; mpid = 0; mcnt = 0;
      sb.delete();
    end else begin
      if (mov && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (peak_clr) begin
        mpeak = 0; mpid = 0; mcnt = 0;
      end
      if (g >= 0) begin
        ref_mag(bus.req_data[g*8 +: 8], m, s);
        r.data = 7'(m); r.id = IDW'(g); r.sat = s;
        sb.push_back(r);
        mov  = 1;
        mptr = (g + 1) % N;
        if (m > mpeak) begin
          mpeak = m; mpid = g;
        end
        if (s && mcnt < 255) mcnt++;
      end else if (adv) begin
        mov = 0;
      end
    end
    #1;
  endtask

  initial begin
    mptr = 0; mov = 0; mpeak = 0; mpid = 0; mcnt = 0;
    rst = 1'b1; peak_clr = 1'b0;
    bus.req_valid = 4'b1111; bus.req_data = '0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cycle();
    check("rst_ready", 32'(seen_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_id", 32'(bus.out_id), 32'h0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'h0);
    rst = 1'b0;

    // single requester, each magnitude case
    bus.req_valid = 4'b0001;
    set_data(0, 8'h05); cycle();
    set_data(0, 8'hFB); cycle();
    set_data(0, 8'h80); cycle();
    set_data(0, 8'h7F); cycle();
    check("t1_last_data", 32'(bus.out_data), 32'd127);
    check("t1_last_sat", 32'(bus.out_sat), 32'h0);
    bus.req_valid = 4'b0000; cycle(); cycle();
    check("t1_sat_cnt", 32'(sat_cnt), 32'd1);
    check("t1_peak_mag", 32'(peak_mag), 32'd127);
    check("t1_peak_id", 32'(peak_id), 32'd0);

    // all requesters valid: rotation, one grant per cycle
    bus.req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'hF0 + i * 3));
    for (int c = 0; c < 8; c++) begin
      cycle();
      check("t2_onehot", 32'($countones(seen_ready)), 32'd1);
    end
    bus.req_valid = 4'b0000; cycle(); cycle();

    // ptr=2 with only 0 and 3 valid
    bus.req_valid = 4'b0010; set_data(1, 8'h22); cycle();
    bus.req_valid = 4'b1001; set_data(0, 8'h33); set_data(3, 8'hCC);
    cycle(); check("t3_grant_a", 32'(seen_ready), 32'h8);
    cycle(); check("t3_grant_b", 32'(seen_ready), 32'h1);
    cycle(); check("t3_grant_c", 32'(seen_ready), 32'h8);
    bus.req_valid = 4'b0000; cycle(); cycle();

    // backpressure stall then release
    bus.req_valid = 4'b0100; set_data(2, 8'hC0); cycle();
    bus.out_ready = 1'b0; bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t4_stall_ready", 32'(seen_ready), 32'h0);
      check("t4_stall_data", 32'(bus.out_data), 32'd64);
    end
    bus.out_ready = 1'b1;
    cycle(); check("t4_release_grant", 32'(seen_ready), 32'h8);
    bus.req_valid = 4'b0000; cycle();
    check("t4_release_id", 32'(bus.out_id), 32'd3);
    cycle();

    // peak clear interplay and sat_cnt saturation
    peak_clr = 1'b1; cycle(); peak_clr = 1'b0;
    check("t5_clr_peak", 32'(peak_mag), 32'h0);
    check("t5_clr_cnt", 32'(sat_cnt), 32'h0);
    bus.req_valid = 4'b0010; set_data(1, 8'd100); cycle();
    check("t5_peak100", 32'(peak_mag), 32'd100);
    peak_clr = 1'b1; bus.req_valid = 4'b0100; set_data(2, 8'hF6); cycle();
    peak_clr = 1'b0;
    check("t5_clrx_mag", 32'(peak_mag), 32'd10);
    check("t5_clrx_id", 32'(peak_id), 32'd2);
    check("t5_clrx_cnt", 32'(sat_cnt), 32'd0);
    bus.req_valid = 4'b0001; set_data(0, 8'h80);
    for (int c = 0; c < 300; c++) cycle();
    check("t5_sat255", 32'(sat_cnt), 32'd255);
    cycle(); cycle();
    check("t5_sat_hold", 32'(sat_cnt), 32'd255);
    bus.req_valid = 4'b0000; cycle();

    // reset while a result is stalled
    bus.req_valid = 4'b0001; set_data(0, 8'h11); cycle();
    bus.out_ready = 1'b0; bus.req_valid = 4'b0110; cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t6_out_valid", 32'(bus.out_valid), 32'h0);
    check("t6_out_data", 32'(bus.out_data), 32'h0);
    check("t6_out_sat", 32'(bus.out_sat), 32'h0);
    check("t6_peak_mag", 32'(peak_mag), 32'h0);
    check("t6_sat_cnt", 32'(sat_cnt), 32'h0);
    bus.out_ready = 1'b1;
    cycle(); check("t6_first_grant", 32'(seen_ready), 32'h2);
    bus.req_valid = 4'b0000; cycle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
